// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises command/data frames from MOSI and
// returns RAM read bytes on MISO, MSB first, for the SPI-to-RAM slave.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int FW = DATA_WIDTH + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  typedef enum logic [1:0] {
    TX_WAIT,
    TX_SHIFT,
    TX_DONE
  } tx_ph_t;

  state_t                  state_q;
  tx_ph_t                  tx_ph_q;
  logic [CW-1:0]           bit_cnt_q;
  logic [FW-1:0]           rx_shift_q;
  logic [FW-1:0]           rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [TW-1:0]           tx_cnt_q;
  logic                    rd_addr_done_q;
  logic                    miso_q;
  logic [FW-1:0]           rx_data_q;
  logic                    rx_valid_q;
  logic                    last_bit;
  logic                    frame_done;
  logic [1:0]              cmd_d;

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // Receive shifter with the current MOSI bit appended
  assign rx_shift_d = {rx_shift_q[FW-2:0], MOSI};
  assign cmd_d      = rx_shift_d[FW-1 -: 2];
  assign last_bit   = (bit_cnt_q == CW'(FW - 1));
  assign frame_done = (bit_cnt_q == CW'(FW));

  // Frame FSM, receive path, read-address tracking and MISO shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tx_ph_q        <= TX_WAIT;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      rd_addr_done_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q != IDLE && SS_n) begin
        // Deselect aborts any frame; partial frames are dropped
        state_q    <= IDLE;
        tx_ph_q    <= TX_WAIT;
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
        tx_shift_q <= '0;
        tx_cnt_q   <= '0;
        miso_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!SS_n) begin
              state_q <= CHK_CMD;
            end
          end
          CHK_CMD: begin
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= CW'(1);
            if (!MOSI) begin
              state_q <= WRITE;
            end else if (rd_addr_done_q) begin
              state_q <= READ_DATA;
            end else begin
              state_q <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_shift_q <= rx_shift_d;
              bit_cnt_q  <= bit_cnt_q + CW'(1);
              if (last_bit) begin
                rx_data_q  <= rx_shift_d;
                rx_valid_q <= 1'b1;
                if (cmd_d == 2'b10) begin
                  rd_addr_done_q <= 1'b1;
                end else if (cmd_d == 2'b11) begin
                  rd_addr_done_q <= 1'b0;
                end
              end
            end else if (state_q == READ_DATA) begin
              case (tx_ph_q)
                TX_WAIT: begin
                  if (tx_valid) begin
                    tx_shift_q <= tx_data;
                    tx_cnt_q   <= TW'(DATA_WIDTH);
                    tx_ph_q    <= TX_SHIFT;
                  end
                end
                TX_SHIFT: begin
                  if (tx_cnt_q != '0) begin
                    miso_q     <= tx_shift_q[DATA_WIDTH-1];
                    tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    tx_cnt_q   <= tx_cnt_q - TW'(1);
                  end else begin
                    miso_q  <= 1'b0;
                    tx_ph_q <= TX_DONE;
                  end
                end
                TX_DONE: begin
                  miso_q <= 1'b0;
                end
                default: begin
                  tx_ph_q <= TX_DONE;
                end
              endcase
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-address, read-data
// frames, aborted frames, unrouted reads and asynchronous reset.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h exp %h at %0t", tag, got, exp, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select, one idle-sample edge (E0), then nbits MOSI bits MSB first
  task automatic send_frame(input logic [9:0] f, input int nbits);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[9-i];
      tick();
      chk("miso_rx", {15'd0, MISO}, 16'd0);
      if (i < 9) chk("rxv_early", {15'd0, rx_valid}, 16'd0);
    end
    if (nbits == 10) begin
      chk("rxv", {15'd0, rx_valid}, 16'd1);
      chk("rxd", {6'd0, rx_data}, {6'd0, f});
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    chk("rxv_off", {15'd0, rx_valid}, 16'd0);
    chk("miso_idle", {15'd0, MISO}, 16'd0);
  endtask

  // RAM answers one edge after rx_valid; byte is latched the edge after
  task automatic resp(input logic [7:0] d);
    tick();
    chk("rxv_pulse", {15'd0, rx_valid}, 16'd0);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    chk("miso_pre", {15'd0, MISO}, 16'd0);
  endtask

  task automatic no_shift(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("miso_quiet", {15'd0, MISO}, 16'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    #12;
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_rxd", {6'd0, rx_data}, 16'd0);
    chk("rst_rxv", {15'd0, rx_valid}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write address and write data
    send_frame(10'h02A, 10);
    end_frame();
    send_frame(10'h15C, 10);
    end_frame();

    // Read address then read data with RAM byte 0x5C
    send_frame(10'h22A, 10);
    end_frame();
    send_frame(10'h300, 10);
    resp(8'h5C);
    exp_b = 8'h5C;
    for (int b = 7; b >= 0; b--) begin
      tick();
      chk("miso_bit", {15'd0, MISO}, {15'd0, exp_b[b]});
    end
    tick();
    chk("miso_tail", {15'd0, MISO}, 16'd0);
    tick();
    chk("miso_hold", {15'd0, MISO}, 16'd0);
    end_frame();

    // Read frame with no address pending lands in READ_ADD
    send_frame(10'h3AA, 10);
    resp(8'hFF);
    no_shift(10);
    end_frame();

    // Aborted write, then the same frame in full
    send_frame(10'h0FF, 5);
    end_frame();
    send_frame(10'h0FF, 10);
    end_frame();

    // Reset during MISO bit 4 of a read-data byte 0x10
    send_frame(10'h210, 10);
    end_frame();
    send_frame(10'h300, 10);
    resp(8'h10);
    exp_b = 8'h10;
    for (int b = 7; b >= 4; b--) begin
      tick();
      chk("miso_pre_rst", {15'd0, MISO}, {15'd0, exp_b[b]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_miso", {15'd0, MISO}, 16'd0);
    chk("arst_rxv", {15'd0, rx_valid}, 16'd0);
    chk("arst_rxd", {6'd0, rx_data}, 16'd0);
    SS_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(10'h0A5, 10);
    end_frame();

    // Reset mid-frame clears a pending read address
    send_frame(10'h210, 10);
    end_frame();
    send_frame(10'h300, 5);
    #2;
    rst_n = 1'b0;
    #1;
    SS_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(10'h300, 10);
    resp(8'hFF);
    no_shift(10);
    end_frame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI-to-RAM slave. Deserialises 10-bit command/data frames from MOSI (framed by `SS_n`) into a parallel word plus a one-cycle `rx_valid` strobe for the downstream `ram` block. On read-data frames it waits for the RAM's `tx_valid`/`dout` response and shifts that byte out on MISO, MSB first. SPI bit clock equals the system clock `clk`.

## Interface
- `DATA_WIDTH`, default 8: width of `tx_data`. The receive frame is `DATA_WIDTH+2` bits.
- `clk`  in  1  system/SPI clock; all sampling on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `SS_n`  in  1  slave select, active-low; frames a transaction.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; registered.
- `rx_data`  out  DATA_WIDTH+2  assembled frame; `[9:8]` is the command, `[7:0]` is the payload.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `tx_data`  in  DATA_WIDTH  read byte from RAM (`dout`).
- `tx_valid`  in  1  RAM read-response strobe.

## Operation
- Reset (async, `rst_n`=0): `MISO`=0, `rx_data`=0, `rx_valid`=0.
  - Internal reset values: state IDLE, bit counter 0, `rd_addr_done`=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: when `SS_n` is sampled 0, go to CHK_CMD. No MOSI capture occurs in this cycle.
- CHK_CMD: sample MOSI as frame bit 9, then branch:
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_done`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_done`=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA capture frame bits 8..0 from MOSI, one per edge.
- After bit 0 is captured:
  - Load the full 10-bit frame into `rx_data` and pulse `rx_valid` for exactly one cycle.
  - Forward the frame unmodified; the command bits are not checked against the state.
  - Extra MOSI bits after bit 0 are ignored until `SS_n` rises.
- `rd_addr_done` is set when a frame with `rx_data[9:8]`=2'b10 is forwarded. It is cleared when a frame with 2'b11 is forwarded.
- READ_DATA, after forwarding:
  - Wait for `tx_valid`=1, then latch `tx_data` into the output shifter.
  - Drive `MISO` from bit 7 down to bit 0, one bit per cycle.
  - After bit 0, drive `MISO`=0 and hold until `SS_n` rises.
  - `tx_valid` is ignored in every other state and phase.
- `SS_n` sampled 1 in any non-IDLE state: next state is IDLE.
  - Bit counter, receive shifter and output shifter are cleared; `MISO`=0.
  - A partial frame never produces `rx_valid`.
  - `rd_addr_done` is unchanged.
- No timeout. If `tx_valid` never arrives, the block waits in READ_DATA until `SS_n` rises.

## Timing
- Let E0 be the edge at which `SS_n`=0 is first sampled in IDLE.
- Frame bit k is sampled at edge E(10−k): bit 9 at E1, bit 0 at E10.
- `rx_data` and `rx_valid` update at E10; `rx_valid`=1 in the cycle after E10 only.
- Downstream `ram` registers `tx_valid` one edge later (E11), so `tx_valid`=1 in the cycle after E11.
- `tx_data` is latched at E12. `MISO` shows bit 7 from E13 and bit 0 from E20.
  - If `tx_valid` arrives later, the sequence shifts by the same delay.
- Minimum `SS_n`-low time: 11 edges for a write or address frame, 21 edges for a read-data frame.
- Asynchronous reset asserted mid-frame or mid-MISO:
  - Outputs go to reset values immediately and `rd_addr_done` clears.
  - After release, the block waits in IDLE for `SS_n`=0.
  - If `SS_n` is still low at release, a new frame starts; the bench deasserts `SS_n` before release.
- Back-to-back frames: `SS_n` high for at least one sampled edge between frames.

## Test plan
- Write address 0x2A (MOSI 00_0010_1010) → `rx_data`=0x02A, `rx_valid` high one cycle after E10, `MISO`=0 throughout.
- Write data 0x5C (01_0101_1100) → `rx_data`=0x15C, a single `rx_valid` pulse, `rd_addr_done` stays 0.
- Read address 0x2A (10_0010_1010) → state READ_ADD, `rx_data`=0x22A, `rd_addr_done`=1.
  - Then read data (11_0000_0000) → state READ_DATA, `rx_data`=0x300.
  - With RAM model returning `tx_valid` with 0x5C at E11 → `MISO`=0,1,0,1,1,1,0,0 from E13 to E20; `rd_addr_done`=0.
- `SS_n` raised after 5 bits of a write → no `rx_valid`. The next full write frame 0x0FF is received correctly as 0x0FF.
- Read frame with first bit 1 while `rd_addr_done`=0 → routed to READ_ADD; no MISO shifting even if `tx_valid` is pulsed.
- `rst_n` pulsed low during MISO bit 4 → `MISO`=0 immediately, `rx_valid`=0, `rd_addr_done`=0; a subsequent write frame is received correctly.
